// File: rtl/dmem_lat.sv
// Byte-addressed little-endian data RAM for the RV32 load/store unit.
// Valid/ready request, single-pulse response, configurable read/write latency.
module dmem_lat #(
    parameter int MEM_SIZE_KB   = 4,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [31:0] addr,
    input  logic [2:0]  funct3,
    input  logic [31:0] writeData,
    output logic        respValid,
    output logic [31:0] readData,
    output logic        accessFault
);
    localparam int AW    = $clog2(MEM_SIZE_KB * 1024);
    localparam int WORDS = MEM_SIZE_KB * 256;
    localparam logic [2:0] RD_LAT = 3'(READ_LATENCY);
    localparam logic [2:0] WR_LAT = 3'(WRITE_LATENCY);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [2:0]  cnt;
    logic [31:0] mem [WORDS];

    logic [AW-1:0] latAddr;
    logic [2:0]    latF3;
    logic [31:0]   latData;
    logic          latLoad;
    logic          latFault;

    logic          accept, reqFault, enterResp, commit;
    logic [2:0]    reqLat;
    logic [AW-1:0] curAddr;
    logic [2:0]    curF3;
    logic [31:0]   curData;
    logic          curLoad, curFault;
    logic [AW-3:0] idx;
    logic [1:0]    lane;
    logic [31:0]   rword, loadVal, wword;
    logic [7:0]    rbyte;
    logic [15:0]   rhalf;
    logic [3:0]    be;
    logic          unusedAddrHi;

    assign unusedAddrHi = ^addr[31:AW];
    assign accept       = reqValid && reqReady;

    always_comb begin
        reqFault = 1'b0;
        if (memRead == memWrite) begin
            reqFault = 1'b1;
        end else if (memRead) begin
            case (funct3)
                3'd0, 3'd4: reqFault = 1'b0;
                3'd1, 3'd5: reqFault = addr[0];
                3'd2:       reqFault = |addr[1:0];
                default:    reqFault = 1'b1;
            endcase
        end else begin
            case (funct3)
                3'd0:    reqFault = 1'b0;
                3'd1:    reqFault = addr[0];
                3'd2:    reqFault = |addr[1:0];
                default: reqFault = 1'b1;
            endcase
        end
        reqLat = (memRead && !reqFault) ? RD_LAT : WR_LAT;
    end

    // With LAT==1 the RESP entry edge is the acceptance edge, so the request
    // inputs are used directly while IDLE; later edges use the latched copy.
    always_comb begin
        curAddr  = (state == IDLE) ? addr[AW-1:0] : latAddr;
        curF3    = (state == IDLE) ? funct3       : latF3;
        curData  = (state == IDLE) ? writeData    : latData;
        curLoad  = (state == IDLE) ? memRead      : latLoad;
        curFault = (state == IDLE) ? reqFault     : latFault;

        idx   = curAddr[AW-1:2];
        lane  = curAddr[1:0];
        rword = mem[idx];
        rbyte = 8'(rword >> {lane, 3'b000});
        rhalf = lane[1] ? rword[31:16] : rword[15:0];

        case (curF3)
            3'd0:    loadVal = {{24{rbyte[7]}}, rbyte};
            3'd4:    loadVal = {24'd0, rbyte};
            3'd1:    loadVal = {{16{rhalf[15]}}, rhalf};
            3'd5:    loadVal = {16'd0, rhalf};
            3'd2:    loadVal = rword;
            default: loadVal = '0;
        endcase

        case (curF3)
            3'd0: begin
                be    = 4'b0001 << lane;
                wword = {4{curData[7:0]}};
            end
            3'd1: begin
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wword = {2{curData[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wword = curData;
            end
        endcase
    end

    // RESP is entered at edge E0+LAT-1 so respValid is sampled by the core at
    // edge E0+LAT and the next request can be accepted at edge E0+LAT+1.
    assign enterResp = (state == IDLE && accept && reqLat == 3'd1) ||
                       (state == WAIT && cnt == 3'd1);
    assign commit    = enterResp && !curLoad && !curFault && !rst;

    always_ff @(posedge clk) begin
        if (commit) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            reqReady    <= 1'b1;
            respValid   <= 1'b0;
            readData    <= '0;
            accessFault <= 1'b0;
        end else begin
            respValid   <= 1'b0;
            accessFault <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        latAddr  <= addr[AW-1:0];
                        latF3    <= funct3;
                        latData  <= writeData;
                        latLoad  <= memRead;
                        latFault <= reqFault;
                        reqReady <= 1'b0;
                        cnt      <= reqLat - 3'd1;
                        state    <= (reqLat == 3'd1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 3'd1) state <= RESP;
                    else             cnt   <= cnt - 3'd1;
                end
                RESP: begin
                    state    <= IDLE;
                    reqReady <= 1'b1;
                end
                default: state <= IDLE;
            endcase
            if (enterResp) begin
                respValid   <= 1'b1;
                accessFault <= curFault;
                if (curFault)     readData <= '0;
                else if (curLoad) readData <= loadVal;
            end
        end
    end
endmodule

// File: tb/tb_dmem_lat.sv
// Directed bench for dmem_lat: four instances with different size/latency
// settings, selected one at a time through gated reqValid/reset.
module tb_dmem_lat;
    logic        clk = 1'b0;
    logic        rst, rstPulse;
    logic        reqValid, memRead, memWrite;
    logic [31:0] addr, writeData;
    logic [2:0]  funct3;
    int          sel;

    logic        vI[4], rstI[4], rdy[4], rv[4], flt[4];
    logic [31:0] rdat[4];

    int nAssert = 0;
    int nFail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : gate
        assign vI[g]   = reqValid && (sel == g);
        assign rstI[g] = rst || (rstPulse && (sel == g));
    end

    dmem_lat #(.MEM_SIZE_KB(4), .READ_LATENCY(2), .WRITE_LATENCY(1)) uA (
        .clk(clk), .rst(rstI[0]), .reqValid(vI[0]), .reqReady(rdy[0]),
        .memRead(memRead), .memWrite(memWrite), .addr(addr), .funct3(funct3),
        .writeData(writeData), .respValid(rv[0]), .readData(rdat[0]), .accessFault(flt[0]));
    dmem_lat #(.MEM_SIZE_KB(1), .READ_LATENCY(1), .WRITE_LATENCY(3)) uB (
        .clk(clk), .rst(rstI[1]), .reqValid(vI[1]), .reqReady(rdy[1]),
        .memRead(memRead), .memWrite(memWrite), .addr(addr), .funct3(funct3),
        .writeData(writeData), .respValid(rv[1]), .readData(rdat[1]), .accessFault(flt[1]));
    dmem_lat #(.MEM_SIZE_KB(4), .READ_LATENCY(4), .WRITE_LATENCY(1)) uC (
        .clk(clk), .rst(rstI[2]), .reqValid(vI[2]), .reqReady(rdy[2]),
        .memRead(memRead), .memWrite(memWrite), .addr(addr), .funct3(funct3),
        .writeData(writeData), .respValid(rv[2]), .readData(rdat[2]), .accessFault(flt[2]));
    dmem_lat #(.MEM_SIZE_KB(4), .READ_LATENCY(7), .WRITE_LATENCY(1)) uD (
        .clk(clk), .rst(rstI[3]), .reqValid(vI[3]), .reqReady(rdy[3]),
        .memRead(memRead), .memWrite(memWrite), .addr(addr), .funct3(funct3),
        .writeData(writeData), .respValid(rv[3]), .readData(rdat[3]), .accessFault(flt[3]));

    typedef struct {
        int          s;
        logic        rd, wr;
        logic [31:0] a;
        logic [2:0]  f;
        logic [31:0] wd;
        logic [31:0] expD;
        logic        expF;
        int          expLat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int s, input logic rd, input logic wr,
                                input logic [31:0] a, input logic [2:0] f,
                                input logic [31:0] wd, input logic [31:0] expD,
                                input logic expF, input int expLat);
        vec_t v;
        v.s = s; v.rd = rd; v.wr = wr; v.a = a; v.f = f; v.wd = wd;
        v.expD = expD; v.expF = expF; v.expLat = expLat;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nAssert++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One request; lat = number of edges from acceptance to the edge at
    // which respValid is sampled high (0 if it never arrives).
    task automatic xact(input int s, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [2:0] f, input logic [31:0] wd,
                        output logic [31:0] data, output logic fault, output int lat);
        sel = s;
        @(negedge clk);
        check("idle respValid", 32'(rv[s]), 32'd0);
        check("idle reqReady", 32'(rdy[s]), 32'd1);
        memRead = rd; memWrite = wr; addr = a; funct3 = f; writeData = wd;
        reqValid = 1'b1;
        @(negedge clk);
        reqValid = 1'b0;
        memRead = 1'b0; memWrite = 1'b0; addr = '1; funct3 = 3'd7; writeData = '1;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            check("busy reqReady", 32'(rdy[s]), 32'd0);
            if (rv[s]) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        data  = rdat[s];
        fault = flt[s];
    endtask

    task automatic bb(input int s, input int lat);
        int  lastAcc, nAcc, nResp;
        bit  done;
        sel = s;
        @(negedge clk);
        memRead = 1'b1; memWrite = 1'b0; funct3 = 3'd2; addr = '0;
        check("bb first ready", 32'(rdy[s]), 32'd1);
        reqValid = 1'b1;
        lastAcc = 0; nAcc = 1; nResp = 0; done = 1'b0;
        for (int n = 1; n <= 40 && !done; n++) begin
            @(negedge clk);
            if (rv[s]) begin
                nResp++;
                check("bb resp spacing", n - lastAcc, lat);
            end
            if (rdy[s]) begin
                check("bb accept spacing", n - lastAcc, lat + 1);
                if (nAcc == 3) begin
                    reqValid = 1'b0;
                    done = 1'b1;
                end else begin
                    lastAcc = n;
                    nAcc++;
                end
            end
        end
        reqValid = 1'b0;
        memRead  = 1'b0;
        check("bb completed", 32'(done), 32'd1);
        check("bb responses", nResp, 3);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        f;
        int          l;

        rst = 1'b1; rstPulse = 1'b0; reqValid = 1'b0; sel = 0;
        memRead = 1'b0; memWrite = 1'b0; addr = '0; funct3 = '0; writeData = '0;

        // instance A: 4 KiB, read 2, write 1
        vecs.push_back(mk(0, 0, 1, 32'h8,    3'd2, 32'hDEADBEEF, 32'h00000000, 0, 1));
        vecs.push_back(mk(0, 1, 0, 32'h8,    3'd2, 32'h0,        32'hDEADBEEF, 0, 2));
        vecs.push_back(mk(0, 0, 1, 32'h10,   3'd2, 32'h11223344, 32'hDEADBEEF, 0, 1));
        vecs.push_back(mk(0, 0, 1, 32'h11,   3'd0, 32'h123456AA, 32'hDEADBEEF, 0, 1));
        vecs.push_back(mk(0, 0, 1, 32'h12,   3'd1, 32'hFFFF8001, 32'hDEADBEEF, 0, 1));
        vecs.push_back(mk(0, 1, 0, 32'h10,   3'd2, 32'h0,        32'h8001AA44, 0, 2));
        vecs.push_back(mk(0, 1, 0, 32'h11,   3'd0, 32'h0,        32'hFFFFFFAA, 0, 2));
        vecs.push_back(mk(0, 1, 0, 32'h11,   3'd4, 32'h0,        32'h000000AA, 0, 2));
        vecs.push_back(mk(0, 1, 0, 32'h12,   3'd1, 32'h0,        32'hFFFF8001, 0, 2));
        vecs.push_back(mk(0, 1, 0, 32'h12,   3'd5, 32'h0,        32'h00008001, 0, 2));
        vecs.push_back(mk(0, 1, 0, 32'h10,   3'd0, 32'h0,        32'h00000044, 0, 2));
        vecs.push_back(mk(0, 1, 0, 32'h10,   3'd1, 32'h0,        32'hFFFFAA44, 0, 2));
        vecs.push_back(mk(0, 1, 0, 32'h13,   3'd4, 32'h0,        32'h00000080, 0, 2));
        vecs.push_back(mk(0, 0, 1, 32'h100,  3'd2, 32'hCAFEF00D, 32'h00000080, 0, 1));
        vecs.push_back(mk(0, 1, 0, 32'h102,  3'd2, 32'h0,        32'h00000000, 1, 1));
        vecs.push_back(mk(0, 0, 1, 32'h101,  3'd1, 32'h0000FFFF, 32'h00000000, 1, 1));
        vecs.push_back(mk(0, 1, 0, 32'h100,  3'd3, 32'h0,        32'h00000000, 1, 1));
        vecs.push_back(mk(0, 1, 1, 32'h100,  3'd2, 32'h0,        32'h00000000, 1, 1));
        vecs.push_back(mk(0, 0, 0, 32'h100,  3'd2, 32'h0,        32'h00000000, 1, 1));
        vecs.push_back(mk(0, 0, 1, 32'h100,  3'd4, 32'h00000011, 32'h00000000, 1, 1));
        vecs.push_back(mk(0, 1, 0, 32'h100,  3'd2, 32'h0,        32'hCAFEF00D, 0, 2));
        vecs.push_back(mk(0, 1, 0, 32'h1008, 3'd2, 32'h0,        32'hDEADBEEF, 0, 2));
        vecs.push_back(mk(0, 0, 1, 32'h103,  3'd0, 32'h00000055, 32'hDEADBEEF, 0, 1));
        vecs.push_back(mk(0, 1, 0, 32'h100,  3'd2, 32'h0,        32'h55FEF00D, 0, 2));
        // instance B: 1 KiB, read 1, write 3 (address wrap)
        vecs.push_back(mk(1, 0, 1, 32'h33242344, 3'd2, 32'd233,  32'h00000000, 0, 3));
        vecs.push_back(mk(1, 1, 0, 32'h344,  3'd2, 32'h0,        32'd233,      0, 1));
        vecs.push_back(mk(1, 1, 0, 32'h744,  3'd2, 32'h0,        32'd233,      0, 1));
        // instances C and D: read latency 4 and 7
        vecs.push_back(mk(2, 0, 1, 32'h40,   3'd2, 32'h12345678, 32'h00000000, 0, 1));
        vecs.push_back(mk(2, 1, 0, 32'h40,   3'd2, 32'h0,        32'h12345678, 0, 4));
        vecs.push_back(mk(3, 0, 1, 32'h40,   3'd2, 32'h0BADCAFE, 32'h00000000, 0, 1));
        vecs.push_back(mk(3, 1, 0, 32'h42,   3'd1, 32'h0,        32'h00000BAD, 0, 7));

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset reqReady", 32'(rdy[0]), 32'd1);
        check("reset respValid", 32'(rv[0]), 32'd0);
        check("reset readData", rdat[0], 32'd0);
        check("reset accessFault", 32'(flt[0]), 32'd0);
        check("reset reqReady B", 32'(rdy[1]), 32'd1);

        foreach (vecs[i]) begin
            xact(vecs[i].s, vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].f, vecs[i].wd, d, f, l);
            check($sformatf("v%0d readData", i), d, vecs[i].expD);
            check($sformatf("v%0d accessFault", i), 32'(f), 32'(vecs[i].expF));
            check($sformatf("v%0d latency", i), l, vecs[i].expLat);
        end

        bb(1, 1);
        bb(2, 4);
        bb(3, 7);

        // store interrupted by reset during WAIT must not commit
        xact(1, 0, 1, 32'h20, 3'd2, 32'd5, d, f, l);
        check("prestore latency", l, 3);
        sel = 1;
        @(negedge clk);
        check("rst seq ready", 32'(rdy[1]), 32'd1);
        memRead = 1'b0; memWrite = 1'b1; addr = 32'h20; funct3 = 3'd2; writeData = 32'd99;
        reqValid = 1'b1;
        @(negedge clk);
        reqValid = 1'b0; memWrite = 1'b0;
        check("rst seq in WAIT", 32'(rdy[1]), 32'd0);
        rstPulse = 1'b1;
        @(negedge clk);
        rstPulse = 1'b0;
        check("rst seq respValid", 32'(rv[1]), 32'd0);
        check("rst seq reqReady", 32'(rdy[1]), 32'd1);
        check("rst seq readData", rdat[1], 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("rst seq no late resp", 32'(rv[1]), 32'd0);
        end
        xact(1, 1, 0, 32'h20, 3'd2, 32'h0, d, f, l);
        check("rst seq load data", d, 32'd5);
        check("rst seq load fault", 32'(f), 32'd0);
        check("rst seq load latency", l, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end
endmodule
